// File: rtl/sif_pkg.sv
// Shared constants and types for the sen/sd serial link receive path.
// Holds the FSM state encoding and the default/inverse link widths.
package sif_pkg;

  localparam int SIF_ADDR_W = 3;
  localparam int SIF_DATA_W = 18;
  localparam int SIF_FRAMES = 8;

  localparam int SIF_TX_ADDR_W = 5;
  localparam int SIF_TX_DATA_W = 8;
  localparam int SIF_TX_FRAMES = 18;

  localparam int SIF_FRAME_W    = SIF_ADDR_W + SIF_DATA_W;
  localparam int SIF_TX_FRAME_W = SIF_TX_ADDR_W + SIF_TX_DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WRITE = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } sif_state_e;

  function automatic int frame_w(input int a, input int d);
    return a + d;
  endfunction

endpackage

// File: rtl/sif_rx_frame.sv
// Bit counter and MSB-first shift register for one sen/sd frame.
// frame_full_o marks the edge that captures the last frame bit.
module sif_rx_frame
  import sif_pkg::*;
#(
  parameter int FRAME_W = SIF_FRAME_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic               sen_i,
  input  logic               sd_i,
  output logic               frame_full_o,
  output logic               short_frame_o,
  output logic [FRAME_W-1:0] frame_data_o
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] sr_q, sr_d;

  assign frame_full_o  = shift_i && (cnt_q == LAST);
  assign short_frame_o = sen_i && (cnt_q != '0);
  assign frame_data_o  = {sr_q[FRAME_W-2:0], sd_i};

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clr_i) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (shift_i) begin
      sr_d  = frame_data_o;
      cnt_d = frame_full_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/sif_rx.sv
// sen/sd link receiver: frames in, register-bank write strobes out.
// SIF_RX_ERR_EN enables frame_err / err_cnt; otherwise they read 0.
module sif_rx
  import sif_pkg::*;
#(
  parameter int ADDR_W = SIF_ADDR_W,
  parameter int DATA_W = SIF_DATA_W,
  parameter int FRAMES = SIF_FRAMES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sen,
  input  logic              sd,
  output logic              RB_RW,
  output logic [ADDR_W-1:0] RB_A,
  output logic [DATA_W-1:0] RB_D,
  output logic              done,
  output logic              frame_err,
  output logic [7:0]        err_cnt
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int FCNT_W  = $clog2(FRAMES + 1);
  localparam logic [FCNT_W-1:0] FLAST = FCNT_W'(FRAMES - 1);

  sif_state_e state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic gap_q, gap_d;
  logic rw_q, done_q;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;

  logic rx_ok, shift, clr;
  logic full, short_raw, short_ev;
  logic [FRAME_W-1:0] fdata;

  // GAP already satisfied by sen=1 during WRITE behaves like WAIT
  assign rx_ok = (state_q == ST_WAIT) ||
                 (state_q == ST_SHIFT) ||
                 (state_q == ST_GAP && gap_q);
  assign shift = en && !sen && rx_ok;
  assign short_ev = en && short_raw &&
                    (state_q == ST_SHIFT);
  assign clr = !en || !rx_ok || short_ev;

  sif_rx_frame #(.FRAME_W(FRAME_W)) u_frame (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr),
    .shift_i      (shift),
    .sen_i        (sen),
    .sd_i         (sd),
    .frame_full_o (full),
    .short_frame_o(short_raw),
    .frame_data_o (fdata)
  );

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    gap_d   = gap_q;
    if (!en) begin
      state_d = ST_IDLE;
      fcnt_d  = '0;
      gap_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_WAIT;
        ST_WAIT, ST_SHIFT: begin
          if (full)       state_d = ST_WRITE;
          else if (shift) state_d = ST_SHIFT;
          else            state_d = ST_WAIT;
        end
        ST_WRITE: begin
          gap_d = sen;
          if (!sen) begin
            state_d = ST_GAP;
          end else begin
            fcnt_d  = fcnt_q + FCNT_W'(1);
            state_d = (fcnt_q == FLAST) ? ST_DONE : ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_q) begin
            gap_d = 1'b0;
            if (full)       state_d = ST_WRITE;
            else if (shift) state_d = ST_SHIFT;
            else            state_d = ST_WAIT;
          end else if (sen) begin
            state_d = ST_WAIT;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      gap_q   <= 1'b0;
      rw_q    <= 1'b1;
      a_q     <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      gap_q   <= gap_d;
      rw_q    <= !full;
      done_q  <= (state_d == ST_DONE);
      if (full) begin
        a_q <= fdata[FRAME_W-1 -: ADDR_W];
        d_q <= fdata[DATA_W-1:0];
      end
    end
  end

  assign RB_RW = rw_q;
  assign RB_A  = a_q;
  assign RB_D  = d_q;
  assign done  = done_q;

`ifdef SIF_RX_ERR_EN
  logic ovr_ev, err_d, err_q;
  logic [7:0] ecnt_q;

  // first extra bit is always sampled while in WRITE
  assign ovr_ev = en && !sen && (state_q == ST_WRITE);
  assign err_d  = short_ev || ovr_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      ecnt_q <= '0;
    end else begin
      err_q <= err_d;
      if (err_d && ecnt_q != 8'hFF)
        ecnt_q <= ecnt_q + 8'd1;
    end
  end

  assign frame_err = err_q;
  assign err_cnt   = ecnt_q;
`else
  assign frame_err = 1'b0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_sif_rx.sv
// Self-checking bench for sif_rx: frame table, timing sequences, random.
// Expected writes/errors come from a frame-level model of the link rules.
module tb_sif_rx;

`ifdef SIF_RX_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, sen, sd;
  logic        RB_RW;
  logic [2:0]  RB_A;
  logic [17:0] RB_D;
  logic        done, frame_err;
  logic [7:0]  err_cnt;

  sif_rx dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sen      (sen),
    .sd       (sd),
    .RB_RW    (RB_RW),
    .RB_A     (RB_A),
    .RB_D     (RB_D),
    .done     (done),
    .frame_err(frame_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int err_seen = 0;
  int exp_err = 0;
  int mcnt = 0;
  bit mdone = 1'b0;
  logic [20:0] wq[$];
  logic [20:0] exq[$];

  typedef struct {
    int          nb;
    logic [2:0]  a;
    logic [17:0] d;
    int          wr;
    int          err;
  } vec_t;

  vec_t tbl[7];

  always @(negedge clk) begin
    if (!rst) begin
      if (RB_RW === 1'b0) wq.push_back({RB_A, RB_D});
      if (frame_err === 1'b1) err_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] a, input logic [17:0] d,
                      input int nb, input int gap);
    logic [20:0] w;
    w = {a, d};
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      sen = 1'b0;
      sd  = (i < 21) ? w[20-i] : 1'($urandom);
    end
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      sen = 1'b1;
      sd  = 1'($urandom);
    end
  endtask

  // frame-level link rules: what a frame of nb bits should produce
  function automatic void model(input logic [2:0] a,
                                input logic [17:0] d,
                                input int nb);
    if (mdone) return;
    if (nb < 21) begin
      exp_err += ERR_EN;
    end else begin
      exq.push_back({a, d});
      if (nb > 21) exp_err += ERR_EN;
      else begin
        mcnt++;
        if (mcnt == 8) mdone = 1'b1;
      end
    end
  endfunction

  task automatic mframe(input logic [2:0] a, input logic [17:0] d,
                        input int nb, input int gap);
    model(a, d, nb);
    send(a, d, nb, gap);
  endtask

  task automatic arm();
    cyc(1);
    wq.delete();
    exq.delete();
    mcnt  = 0;
    mdone = 1'b0;
    en  = 1'b1;
    sen = 1'b1;
  endtask

  task automatic disarm();
    @(negedge clk);
    en  = 1'b0;
    sen = 1'b1;
    cyc(2);
  endtask

  task automatic cmp_writes(input string nm);
    chk({nm, " wr count"}, wq.size(), exq.size());
    for (int i = 0; i < wq.size() && i < exq.size(); i++)
      chk({nm, " wr data"}, wq[i], exq[i]);
    chk({nm, " err pulses"}, err_seen, exp_err);
    chk({nm, " err_cnt"}, err_cnt, exp_err);
  endtask

  initial begin
    int w0, e0, nb, u;
    logic [2:0]  ra;
    logic [17:0] rd;

    tbl[0] = '{21, 3'd5, 18'h2A5A5, 1, 0};
    tbl[1] = '{10, 3'd3, 18'h01234, 0, 1};
    tbl[2] = '{23, 3'd6, 18'h3FFFF, 1, 1};
    tbl[3] = '{1,  3'd1, 18'h00000, 0, 1};
    tbl[4] = '{20, 3'd2, 18'h15555, 0, 1};
    tbl[5] = '{22, 3'd0, 18'h00001, 1, 1};
    tbl[6] = '{21, 3'd7, 18'h0ABCD, 1, 0};

    rst = 1'b1;
    repeat (2) begin
      en  = 1'($urandom);
      sen = 1'($urandom);
      sd  = 1'($urandom);
      @(negedge clk);
    end
    chk("reset RB_RW", RB_RW, 1);
    chk("reset RB_A", RB_A, 0);
    chk("reset RB_D", RB_D, 0);
    chk("reset done", done, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset err_cnt", err_cnt, 0);
    rst = 1'b0;
    en  = 1'b0;
    sen = 1'b1;
    cyc(2);

    arm();
    foreach (tbl[k]) begin
      w0 = wq.size();
      e0 = err_seen;
      send(tbl[k].a, tbl[k].d, tbl[k].nb, 2);
      cyc(2);
      exp_err += tbl[k].err * ERR_EN;
      chk("table wr count", wq.size() - w0, tbl[k].wr);
      if (tbl[k].wr != 0 && wq.size() > w0)
        chk("table wr data", wq[w0], {tbl[k].a, tbl[k].d});
      chk("table err pulse", err_seen - e0, tbl[k].err * ERR_EN);
      chk("table err_cnt", err_cnt, exp_err);
    end
    chk("table done", done, 0);
    disarm();

    arm();
    send(3'd5, 18'h2A5A5, 21, 0);
    @(negedge clk);
    sen = 1'b1;
    chk("single strobe", RB_RW, 0);
    chk("single RB_A", RB_A, 5);
    chk("single RB_D", RB_D, 18'h2A5A5);
    @(negedge clk);
    chk("single strobe end", RB_RW, 1);
    chk("single RB_A hold", RB_A, 5);
    disarm();

    arm();
    for (int k = 7; k > 0; k--)
      mframe(3'(k), 18'(k * 18'h01111), 21, 1);
    mframe(3'd0, 18'h0, 21, 0);
    @(negedge clk);
    sen = 1'b1;
    chk("full last strobe", RB_RW, 0);
    chk("full done early", done, 0);
    @(negedge clk);
    chk("full done", done, 1);
    en = 1'b0;
    @(negedge clk);
    chk("full done clear", done, 0);
    cyc(1);
    cmp_writes("full");

    arm();
    model(3'd4, 18'h3C3C3, 10);
    send(3'd4, 18'h3C3C3, 10, 0);
    @(negedge clk);
    sen = 1'b1;
    @(negedge clk);
    chk("short err pulse", frame_err, ERR_EN);
    chk("short no strobe", RB_RW, 1);
    @(negedge clk);
    chk("short err end", frame_err, 0);
    for (int k = 0; k < 8; k++)
      mframe(3'(k), 18'($urandom), 21, 1);
    cyc(3);
    chk("short then done", done, 1);
    cmp_writes("short");
    disarm();

    arm();
    model(3'd6, 18'h12345, 23);
    send(3'd6, 18'h12345, 22, 0);
    chk("ovr strobe", RB_RW, 0);
    @(negedge clk);
    sd = 1'($urandom);
    chk("ovr err pulse", frame_err, ERR_EN);
    @(negedge clk);
    sen = 1'b1;
    chk("ovr err end", frame_err, 0);
    cyc(3);
    cmp_writes("overrun");
    disarm();

    arm();
    mframe(3'd1, 18'h11111, 21, 1);
    mframe(3'd2, 18'h22222, 21, 1);
    send(3'd3, 18'h33333, 12, 0);
    @(negedge clk);
    en  = 1'b0;
    sen = 1'b1;
    cyc(3);
    chk("abort done", done, 0);
    cmp_writes("abort");
    arm();
    for (int k = 0; k < 8; k++)
      mframe(3'(7 - k), 18'($urandom), 21, 1);
    cyc(3);
    chk("rearm done", done, 1);
    cmp_writes("rearm");
    disarm();

    for (int r = 0; r < 4; r++) begin
      arm();
      for (int f = 0; f < 40 && !mdone; f++) begin
        u  = $urandom_range(0, 9);
        nb = (u < 2) ? $urandom_range(1, 20) :
             (u == 2) ? $urandom_range(22, 25) : 21;
        ra = 3'($urandom);
        rd = 18'($urandom);
        mframe(ra, rd, nb, $urandom_range(1, 3));
      end
      cyc(3);
      chk("random done", done, 32'(mdone));
      cmp_writes("random");
      disarm();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
